// File: rtl/datapath_pkg.sv
// datapath_pkg: constants shared by the two-stage datapath and its ALU.
//   - ALU function codes (4-bit aluOp encoding; codes 9..15 are unused and
//     produce a zero result)
//   - bit positions of the flags inside the registered status word
package datapath_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_SHR  = 4'd7;
  localparam logic [3:0] ALU_PASS = 4'd8;

  localparam int NFLAGS = 5;
  localparam int F_Z = 0;
  localparam int F_C = 1;
  localparam int F_N = 2;
  localparam int F_E = 3;
  localparam int F_V = 4;

  typedef logic [NFLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_param.sv
// alu_param: purely combinational WIDTH-bit ALU.
// Ports:
//   op     in  4      function code (datapath_pkg ALU_*)
//   a      in  WIDTH  first operand (op1)
//   b      in  WIDTH  second operand (op2)
//   result out WIDTH  function result, modulo 2^WIDTH
//   fz     out 1      result == 0
//   fc     out 1      ADD carry, SUB borrow, shifted-out bit for SHL/SHR
//   fn     out 1      result MSB
//   fe     out 1      even number of ones in result
//   fv     out 1      signed overflow for ADD/SUB
module alu_param
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             fz,
  output logic             fc,
  output logic             fn,
  output logic             fe,
  output logic             fv
);

  // One extra bit captures the carry (ADD) or the borrow (SUB: the
  // subtraction wraps and sets the top bit exactly when a < b unsigned).
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    fc     = 1'b0;
    fv     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[WIDTH-1:0];
        fc     = sum[WIDTH];
        // Overflow: operands share a sign and the result's sign differs.
        fv     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = diff[WIDTH-1:0];
        fc     = diff[WIDTH];
        // Overflow: operand signs differ and the result's sign differs from a.
        fv     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOT:  result = ~a;
      ALU_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        fc     = a[WIDTH-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        fc     = a[0];
      end
      ALU_PASS: result = b;
      default:  result = '0;
    endcase
  end

  assign fz = (result == '0);
  assign fn = result[WIDTH-1];
  assign fe = ~^result;

endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage datapath.
//   Stage 1: register read with forwarding from the EX/WB register, operand
//            mux (immediate or register), ALU evaluate, capture into EX/WB.
//   Stage 2: write-back of the EX/WB result into the internal register file.
// Handshake: an issue is accepted on a rising edge where in_valid && in_ready;
//   in_ready = ~stall. While stall is high the whole pipeline (EX/WB register,
//   flags, register file) holds and issue inputs are ignored.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_ready  issue handshake; stall freezes the pipeline
//   wen, fwen           instruction writes selRd / updates flags
//   selRd/selRs/selRt   destination / first / second register selects
//   aluOp, t, selT      ALU function, immediate, op2 = selT ? t : reg[selRt]
//   out_valid           aout/rout hold a completed result
//   aout, rout          registered ALU result / registered op1 (forwarded)
//   fZ fC fN fE fV      registered status flags
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 16,
  parameter bit ZERO_R0 = 1'b1,
  localparam int SELW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  output logic             in_ready,
  input  logic             wen,
  input  logic             fwen,
  input  logic [SELW-1:0]  selRd,
  input  logic [SELW-1:0]  selRs,
  input  logic [SELW-1:0]  selRt,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] t,
  input  logic             selT,
  output logic             out_valid,
  output logic [WIDTH-1:0] aout,
  output logic [WIDTH-1:0] rout,
  output logic             fZ,
  output logic             fC,
  output logic             fN,
  output logic             fE,
  output logic             fV
);

  logic [WIDTH-1:0] regs [NREGS];

  // EX/WB pipeline register: aout/rout/out_valid are its visible part.
  logic [SELW-1:0]  rd_q;
  logic             wen_q;
  flags_t           flags_q;

  logic             accept;
  logic             rd_q_live;
  logic             wb_en;
  logic             fwd_rs;
  logic             fwd_rt;
  logic [WIDTH-1:0] rf_rs;
  logic [WIDTH-1:0] rf_rt;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;

  // The EX/WB entry carries a real register write (r0 writes are dropped
  // when r0 is hard-wired, so they must neither forward nor write back).
  assign rd_q_live = out_valid & wen_q & ~(ZERO_R0 && (rd_q == '0));
  assign wb_en     = ~stall & rd_q_live;

  // Register file read; r0 reads as zero when hard-wired.
  assign rf_rs = (ZERO_R0 && (selRs == '0)) ? '0 : regs[selRs];
  assign rf_rt = (ZERO_R0 && (selRt == '0)) ? '0 : regs[selRt];

  // The pending write-back lands on the same edge this read is captured, so
  // the register file still holds the old value: take it from aout instead.
  assign fwd_rs = rd_q_live && (rd_q == selRs);
  assign fwd_rt = rd_q_live && (rd_q == selRt);

  assign op1 = fwd_rs ? aout : rf_rs;
  assign op2 = selT ? t : (fwd_rt ? aout : rf_rt);

  alu_param #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (aluOp),
    .a      (op1),
    .b      (op2),
    .result (alu_res),
    .fz     (alu_flags[F_Z]),
    .fc     (alu_flags[F_C]),
    .fn     (alu_flags[F_N]),
    .fe     (alu_flags[F_E]),
    .fv     (alu_flags[F_V])
  );

  // EX/WB register and status word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      aout      <= '0;
      rout      <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      flags_q   <= '0;
    end else if (!stall) begin
      // A bubble clears valid but leaves aout/rout showing the last result.
      out_valid <= in_valid;
      if (accept) begin
        aout  <= alu_res;
        rout  <= op1;
        rd_q  <= selRd;
        wen_q <= wen;
        if (fwen) begin
          flags_q <= alu_flags;
        end
      end
    end
  end

  // Register file write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[rd_q] <= aout;
    end
  end

  assign fZ = flags_q[F_Z];
  assign fC = flags_q[F_C];
  assign fN = flags_q[F_N];
  assign fE = flags_q[F_E];
  assign fV = flags_q[F_V];

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised, two-stage successor to the single-cycle CPU datapath.
- Stage 1: register read with forwarding, immediate/register operand mux, ALU evaluate, capture into an EX/WB pipeline register.
- Stage 2: write-back into an internal register file; flags are held in a registered status word.
- Sits between the decoder and the memory/branch unit; adds issue/stall handshake and width/depth generality.

Parameters:
- WIDTH, 16, data path width in bits (>= 4).
- NREGS, 16, number of registers (power of two, >= 2).
- SELW, $clog2(NREGS), register select width (derived, not overridden).
- ZERO_R0, 1, when 1 register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction present on issue inputs
- stall  in  1  freeze pipeline; in_ready = ~stall
- in_ready  out  1  issue accepted when in_valid & in_ready
- wen  in  1  instruction writes selRd
- fwen  in  1  instruction updates flags
- selRd  in  SELW  destination
- selRs  in  SELW  first operand
- selRt  in  SELW  second operand
- aluOp  in  4  ALU function
- t  in  WIDTH  immediate
- selT  in  1  1: op2 = t, 0: op2 = reg[selRt]
- out_valid  out  1  aout/rout hold a completed result
- aout  out  WIDTH  registered ALU result
- rout  out  WIDTH  registered op1 value (after forwarding)
- fZ, fC, fN, fE, fV  out  1 each  registered zero/carry/negative/parity/overflow flags

Behaviour:
- Reset (async, immediate): all registers, aout, rout, out_valid, and all flags = 0; the pipeline register is empty.
- Accept: an issue is accepted on a rising edge where in_valid=1 and stall=0. On that edge:
  - the pipeline register loads result, op1, selRd, wen, and valid=1;
  - flags load when fwen=1.
  - Latency: 1 cycle to aout/out_valid.
- Bubble: with stall=0 and in_valid=0, the pipeline register's valid clears on the next edge. aout/rout hold their last values.
- Write-back: on any edge with stall=0 and pipeline valid & wen_q, reg[rd_q] <= aout. This occurs on the same edge a following instruction is captured.
- Stall=1: the pipeline register, flags and register file hold; no write-back. out_valid stays unchanged. Issue inputs are ignored.
- Forwarding: if pipeline valid & wen_q and rd_q equals selRs (or selRt with selT=0), the read uses aout instead of the register file. Exception: rd_q=0 with ZERO_R0=1 never forwards.
- Register 0 (ZERO_R0=1): reads 0, and writes are discarded.
- ALU ops (shared encoding): ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5 (~op1), SHL=6, SHR=7 (logical, shift by 1), PASS=8 (op2). Codes 9–15 yield 0.
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - Z = result==0.
  - N = result[WIDTH-1].
  - E = even number of ones in result (~^result).
  - C = carry out of ADD; for SUB, C = borrow (op1<op2 unsigned); for SHL/SHR, C = the bit shifted out; otherwise 0.
  - V = signed overflow for ADD/SUB; otherwise 0.
- Flags update only when fwen=1 on an accepted issue. When fwen=0, they hold.
- Simultaneous: write-back and a new read of the same register in the same cycle resolve via forwarding, so no stale value is ever read.
- Reset mid-operation discards the in-flight result; no write-back occurs.

Decomposition:
- Shared package datapath_pkg:
  - ALU op localparams (ALU_ADD..ALU_PASS);
  - flag bit index constants (F_Z, F_C, F_N, F_E, F_V).
- Sub-module alu_param: purely combinational; parameter WIDTH; outputs result plus the 5 flags.
- Register file and forwarding stay in datapath_pipe.

Test Plan:
- Reset: assert rst mid-cycle with a pending write → all outputs 0 immediately. After release, reading r1 gives 0.
- Back-to-back forwarding (WIDTH=16):
  - Issue r1=r0+imm 0x0005 (selT=1, PASS on r0 + ADD), then r2=r1+r1 the next cycle.
  - Expect aout 0x0005, then 0x000A.
  - Expect reg r2=0x000A after write-back.
- Flags: ADD 0x7FFF+0x0001 with fwen=1 → aout 0x8000, N=1, V=1, C=0, Z=0, E=0.
  - Then SUB 0x0000−0x0001 → aout 0xFFFF, C=1, N=1, V=0, E=1.
- Stall: issue ADD, then hold stall=1 for 3 cycles with in_valid=1 and a different instruction on the inputs.
  - Expect aout, out_valid and flags frozen, in_ready=0, and no register change.
  - After release, the held instruction is accepted once.
- fwen=0 and ZERO_R0: XOR r0,r0 → r0 with wen=1, fwen=0.
  - Expect flags unchanged and r0 still 0.
  - Expect an immediately following read of r0 not forwarded (returns 0).
- Parametrisation: WIDTH=8, NREGS=4. SHL 0x81 → aout 0x02, C=1. Unused ops 9–15 → aout 0, Z=1.
